time_set_loader: RTL and testbench

Time-set controller for the alarm clock: the writer side of the digit counters' parallel-load interface. On a Set request it captures the running HH:MM digits into shadow registers. It then walks the user through the four digits with Set/Inc buttons and range-checks each digit. Finally it issues a single load strobe that writes all four shadow values into the hour and minute digit counters, which include the 0–3 display counter.

---
 rtl/time_set_loader.sv | 151 +++++++++++++++
 tb/tb_time_set_loader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_loader.sv
// Alarm-clock time-set controller: captures HH:MM, edits each digit
// with Set/Inc buttons, then strobes LD once into the digit counters.
module time_set_loader #(
   parameter int unsigned HOUR_TENS_MAX  = 2,
   parameter int unsigned HOUR_UNITS_TOP = 3
) (
   input  logic       Clk,
   input  logic       Clr,
   input  logic       Set_Btn,
   input  logic       Inc_Btn,
   input  logic       Cancel,
   input  logic [1:0] Cur_H1,
   input  logic [3:0] Cur_H0,
   input  logic [2:0] Cur_M1,
   input  logic [3:0] Cur_M0,
   output logic       Setting,
   output logic [1:0] Edit_Sel,
   output logic       LD,
   output logic [1:0] Ld_H1,
   output logic [3:0] Ld_H0,
   output logic [2:0] Ld_M1,
   output logic [3:0] Ld_M0
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_H1     = 3'd1;
   localparam logic [2:0] S_H0     = 3'd2;
   localparam logic [2:0] S_M1     = 3'd3;
   localparam logic [2:0] S_M0     = 3'd4;
   localparam logic [2:0] S_COMMIT = 3'd5;

   localparam logic [1:0] H1_MAX = 2'(HOUR_TENS_MAX);
   localparam logic [3:0] H0_TOP = 4'(HOUR_UNITS_TOP);

   logic [2:0] state_q, state_d;
   logic [1:0] h1_q, h1_d;
   logic [3:0] h0_q, h0_d;
   logic [2:0] m1_q, m1_d;
   logic [3:0] m0_q, m0_d;

   logic [1:0] h1_inc;
   logic [3:0] h0_lim;
   logic [3:0] h0_inc;
   logic [2:0] m1_inc;
   logic [3:0] m0_inc;

   // Compare against the limit before wrapping so captured illegal
   // values fall back to 0 on their first increment.
   always_comb begin
      h1_inc = (h1_q >= H1_MAX) ? 2'd0 : h1_q + 2'd1;
      h0_lim = (h1_q == H1_MAX) ? H0_TOP : 4'd9;
      h0_inc = (h0_q >= h0_lim) ? 4'd0 : h0_q + 4'd1;
      m1_inc = (m1_q >= 3'd5) ? 3'd0 : m1_q + 3'd1;
      m0_inc = (m0_q >= 4'd9) ? 4'd0 : m0_q + 4'd1;
   end

   always_comb begin
      state_d = state_q;
      h1_d    = h1_q;
      h0_d    = h0_q;
      m1_d    = m1_q;
      m0_d    = m0_q;
      unique case (state_q)
         S_IDLE: begin
            if (Set_Btn) begin
               h1_d    = Cur_H1;
               h0_d    = Cur_H0;
               m1_d    = Cur_M1;
               m0_d    = Cur_M0;
               state_d = S_H1;
            end
         end
         S_H1: begin
            if (Cancel) begin
               state_d = S_IDLE;
            end else if (Set_Btn) begin
               state_d = S_H0;
            end else if (Inc_Btn) begin
               h1_d = h1_inc;
               // Keep the shadow hour legal when entering the top decade
               if (h1_inc == H1_MAX && h0_q > H0_TOP) begin
                  h0_d = 4'd0;
               end
            end
         end
         S_H0: begin
            if (Cancel) begin
               state_d = S_IDLE;
            end else if (Set_Btn) begin
               state_d = S_M1;
            end else if (Inc_Btn) begin
               h0_d = h0_inc;
            end
         end
         S_M1: begin
            if (Cancel) begin
               state_d = S_IDLE;
            end else if (Set_Btn) begin
               state_d = S_M0;
            end else if (Inc_Btn) begin
               m1_d = m1_inc;
            end
         end
         S_M0: begin
            if (Cancel) begin
               state_d = S_IDLE;
            end else if (Set_Btn) begin
               state_d = S_COMMIT;
            end else if (Inc_Btn) begin
               m0_d = m0_inc;
            end
         end
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Clr) begin
         state_q <= S_IDLE;
         h1_q    <= '0;
         h0_q    <= '0;
         m1_q    <= '0;
         m0_q    <= '0;
      end else begin
         state_q <= state_d;
         h1_q    <= h1_d;
         h0_q    <= h0_d;
         m1_q    <= m1_d;
         m0_q    <= m0_d;
      end
   end

   always_comb begin
      Edit_Sel = 2'd0;
      unique case (state_q)
         S_H0:    Edit_Sel = 2'd1;
         S_M1:    Edit_Sel = 2'd2;
         S_M0:    Edit_Sel = 2'd3;
         default: Edit_Sel = 2'd0;
      endcase
   end

   assign Setting = (state_q != S_IDLE);
   assign LD      = (state_q == S_COMMIT);
   assign Ld_H1   = h1_q;
   assign Ld_H0   = h0_q;
   assign Ld_M1   = m1_q;
   assign Ld_M0   = m0_q;

endmodule

// File: tb/tb_time_set_loader.sv
// Directed and randomized bench for time_set_loader with a
// digit-level reference model of the time-set procedure.
module tb_time_set_loader;

   logic       Clk;
   logic       Clr;
   logic       Set_Btn;
   logic       Inc_Btn;
   logic       Cancel;
   logic [1:0] Cur_H1;
   logic [3:0] Cur_H0;
   logic [2:0] Cur_M1;
   logic [3:0] Cur_M0;
   logic       Setting;
   logic [1:0] Edit_Sel;
   logic       LD;
   logic [1:0] Ld_H1;
   logic [3:0] Ld_H0;
   logic [2:0] Ld_M1;
   logic [3:0] Ld_M0;

   int nchk = 0;
   int nerr = 0;

   // Model: pos = -1 idle, 0..3 digit being edited, 4 commit cycle
   int pos = -1;
   int sh[4];

   time_set_loader dut (
      .Clk(Clk), .Clr(Clr), .Set_Btn(Set_Btn), .Inc_Btn(Inc_Btn),
      .Cancel(Cancel), .Cur_H1(Cur_H1), .Cur_H0(Cur_H0),
      .Cur_M1(Cur_M1), .Cur_M0(Cur_M0), .Setting(Setting),
      .Edit_Sel(Edit_Sel), .LD(LD), .Ld_H1(Ld_H1), .Ld_H0(Ld_H0),
      .Ld_M1(Ld_M1), .Ld_M0(Ld_M0)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic int dig_limit(int d);
      case (d)
         0:       return 2;
         1:       return (sh[0] == 2) ? 3 : 9;
         2:       return 5;
         default: return 9;
      endcase
   endfunction

   task automatic model_step(input logic s, i, c, r);
      int nv;
      if (r) begin
         pos = -1;
         foreach (sh[k]) sh[k] = 0;
      end else if (pos == -1) begin
         if (s) begin
            sh[0] = Cur_H1; sh[1] = Cur_H0;
            sh[2] = Cur_M1; sh[3] = Cur_M0;
            pos = 0;
         end
      end else if (pos == 4) begin
         pos = -1;
      end else if (c) begin
         pos = -1;
      end else if (s) begin
         pos = pos + 1;
      end else if (i) begin
         nv = (sh[pos] + 1 > dig_limit(pos)) ? 0 : sh[pos] + 1;
         if (pos == 0 && nv == 2 && sh[1] > 3) sh[1] = 0;
         sh[pos] = nv;
      end
   endtask

   function automatic logic [16:0] model_out();
      logic [1:0] sel;
      sel = (pos >= 0 && pos <= 3) ? 2'(pos) : 2'd0;
      return {pos != -1, pos == 4, sel, 2'(sh[0]), 4'(sh[1]),
              3'(sh[2]), 4'(sh[3])};
   endfunction

   function automatic logic [16:0] dut_out();
      return {Setting, LD, Edit_Sel, Ld_H1, Ld_H0, Ld_M1, Ld_M0};
   endfunction

   function automatic logic [12:0] dut_ld();
      return {Ld_H1, Ld_H0, Ld_M1, Ld_M0};
   endfunction

   task automatic set_cur(input int h1, h0, m1, m0);
      Cur_H1 = 2'(h1); Cur_H0 = 4'(h0);
      Cur_M1 = 3'(m1); Cur_M0 = 4'(m0);
   endtask

   // One clock: drive at negedge, model follows the edge, outputs
   // are then sampled 1 time unit after the rising edge.
   task automatic tick(input logic s, i, c, r);
      @(negedge Clk);
      Set_Btn = s; Inc_Btn = i; Cancel = c; Clr = r;
      @(posedge Clk);
      #1;
      model_step(s, i, c, r);
   endtask

   task automatic test_reset();
      for (int n = 0; n < 2; n++) begin
         set_cur($urandom_range(3), $urandom_range(15),
                 $urandom_range(7), $urandom_range(15));
         tick(1'b1, 1'($urandom), 1'($urandom), 1'b1);
      end
      nchk++;
      if (dut_out() !== 17'd0) begin
         nerr++;
         $display("FAIL reset: got %h want %h", dut_out(), 17'd0);
      end
      tick(0, 0, 0, 0);
      nchk++;
      if (dut_out() !== 17'd0) begin
         nerr++;
         $display("FAIL reset_hold: got %h want %h", dut_out(), 17'd0);
      end
   endtask

   task automatic test_full_edit();
      int lds;
      lds = 0;
      set_cur(1, 2, 3, 4);
      tick(1, 0, 0, 0);
      nchk++;
      if ({Setting, LD, Edit_Sel, dut_ld()} !==
          {1'b1, 1'b0, 2'd0, 2'd1, 4'd2, 3'd3, 4'd4}) begin
         nerr++;
         $display("FAIL full_capture: got %h", dut_out());
      end
      set_cur(0, 0, 0, 0);
      tick(0, 1, 0, 0);
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      nchk++;
      if ({Edit_Sel, dut_ld()} !== {2'd2, 2'd2, 4'd2, 3'd3, 4'd4}) begin
         nerr++;
         $display("FAIL full_mid: got %h", dut_out());
      end
      repeat (2) tick(0, 1, 0, 0);
      tick(1, 0, 0, 0);
      for (int n = 0; n < 5; n++) begin
         tick(0, 1, 0, 0);
         if (LD) lds++;
      end
      tick(1, 0, 0, 0);
      nchk++;
      if ({Setting, LD, dut_ld()} !==
          {1'b1, 1'b1, 2'd2, 4'd2, 3'd5, 4'd9}) begin
         nerr++;
         $display("FAIL full_commit: got %h want 22:59 LD=1", dut_out());
      end
      tick(0, 0, 0, 0);
      nchk++;
      if ({Setting, LD, Edit_Sel, lds} !== {1'b0, 1'b0, 2'd0, 32'd0}) begin
         nerr++;
         $display("FAIL full_after: got %h lds=%0d want idle", dut_out(), lds);
      end
   endtask

   task automatic test_clamp_wrap();
      logic [3:0] seq[4];
      seq = '{4'd1, 4'd2, 4'd3, 4'd0};
      set_cur(1, 9, 0, 0);
      tick(1, 0, 0, 0);
      tick(0, 1, 0, 0);
      nchk++;
      if ({Ld_H1, Ld_H0} !== {2'd2, 4'd0}) begin
         nerr++;
         $display("FAIL clamp: got H1=%0d H0=%0d want 2,0", Ld_H1, Ld_H0);
      end
      tick(1, 0, 0, 0);
      for (int n = 0; n < 4; n++) begin
         tick(0, 1, 0, 0);
         nchk++;
         if (Ld_H0 !== seq[n]) begin
            nerr++;
            $display("FAIL h0_wrap[%0d]: got %0d want %0d", n, Ld_H0, seq[n]);
         end
      end
      tick(0, 0, 1, 0);
      set_cur(2, 3, 0, 0);
      tick(1, 0, 0, 0);
      for (int n = 0; n < 3; n++) begin
         tick(0, 1, 0, 0);
         nchk++;
         if (Ld_H1 !== 2'(n)) begin
            nerr++;
            $display("FAIL h1_wrap[%0d]: got %0d want %0d", n, Ld_H1, n);
         end
      end
      nchk++;
      if (Ld_H0 !== 4'd3) begin
         nerr++;
         $display("FAIL h1_noclamp: got H0=%0d want 3", Ld_H0);
      end
      tick(0, 0, 1, 0);
   endtask

   task automatic test_minute_wrap();
      set_cur(0, 0, 5, 9);
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      tick(0, 1, 0, 0);
      nchk++;
      if (Ld_M1 !== 3'd0) begin
         nerr++;
         $display("FAIL m1_wrap: got %0d want 0", Ld_M1);
      end
      tick(1, 0, 0, 0);
      tick(0, 1, 0, 0);
      nchk++;
      if (Ld_M0 !== 4'd0) begin
         nerr++;
         $display("FAIL m0_wrap: got %0d want 0", Ld_M0);
      end
      tick(1, 0, 0, 0);
      nchk++;
      if ({LD, dut_ld()} !== {1'b1, 13'd0}) begin
         nerr++;
         $display("FAIL minute_commit: got %h want LD 00:00", dut_out());
      end
      tick(0, 0, 0, 0);
   endtask

   task automatic test_priority();
      set_cur(0, 7, 4, 1);
      tick(0, 1, 1, 0);
      nchk++;
      if ({Setting, dut_ld()} !== {1'b0, 13'd0}) begin
         nerr++;
         $display("FAIL idle_ignore: got %h want idle 00:00", dut_out());
      end
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      tick(1, 0, 1, 0);
      nchk++;
      if ({Setting, LD} !== 2'b00) begin
         nerr++;
         $display("FAIL cancel_set: got S=%b LD=%b want 0 0", Setting, LD);
      end
      tick(0, 0, 0, 0);
      nchk++;
      if ({Setting, LD, dut_ld()} !== {2'b00, 2'd0, 4'd7, 3'd4, 4'd1}) begin
         nerr++;
         $display("FAIL cancel_keep: got %h want idle 07:41", dut_out());
      end
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      tick(1, 1, 0, 0);
      nchk++;
      if ({Edit_Sel, Ld_H0} !== {2'd2, 4'd7}) begin
         nerr++;
         $display("FAIL set_inc: got sel=%0d H0=%0d want 2,7", Edit_Sel, Ld_H0);
      end
      tick(0, 0, 1, 0);
   endtask

   task automatic test_reset_mid_edit();
      int lds;
      lds = 0;
      set_cur(0, 8, 4, 5);
      tick(1, 0, 0, 0);
      repeat (3) begin
         tick(1, 0, 0, 0);
         if (LD) lds++;
      end
      tick(1, 0, 0, 1);
      nchk++;
      if ({dut_out(), lds} !== {17'd0, 32'd0}) begin
         nerr++;
         $display("FAIL clr_mid: got %h lds=%0d want 0", dut_out(), lds);
      end
      set_cur(1, 1, 1, 1);
      tick(1, 0, 0, 0);
      nchk++;
      if ({Setting, LD, Edit_Sel, dut_ld()} !==
          {2'b10, 2'd0, 2'd1, 4'd1, 3'd1, 4'd1}) begin
         nerr++;
         $display("FAIL clr_recapture: got %h want edit 11:11", dut_out());
      end
      tick(0, 0, 1, 0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         set_cur($urandom_range(3), $urandom_range(15),
                 $urandom_range(7), $urandom_range(15));
         tick($urandom_range(3) == 0, $urandom_range(2) == 0,
              $urandom_range(15) == 0, $urandom_range(63) == 0);
         nchk++;
         if (dut_out() !== model_out()) begin
            nerr++;
            $display("FAIL random[%0d]: got %h want %h",
                     n, dut_out(), model_out());
         end
      end
   endtask

   initial begin
      Clr = 1'b1; Set_Btn = 1'b0; Inc_Btn = 1'b0; Cancel = 1'b0;
      set_cur(0, 0, 0, 0);
      foreach (sh[k]) sh[k] = 0;
      test_reset();
      test_full_edit();
      test_clamp_wrap();
      test_minute_wrap();
      test_priority();
      test_reset_mid_edit();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
